// File: rtl/alu_issue.sv
// ALU issue stage: accepts one decoded instruction, registers its ALU operands,
// captures the external ALU result one cycle later, and holds it until writeback
// takes it. One operation is in flight at a time.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid && ready are both 1. A valid, once raised, stays up with its payload
// stable until that transfer or a flush/reset. The ready signal does not wait
// on valid.
module alu_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic [31:0]      imm,
    input  logic [31:0]      pc,
    input  logic             flush,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             zero,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_COPYA = 4'd9;

    logic [1:0]  state;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        illegal_q;

    logic [3:0]  d_op;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic        d_ill;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign illegal   = illegal_q;
    assign state_dbg = state;

    // Decode the offered instruction into ALU op and operand selection.
    always_comb begin
        d_op  = OP_ADD;
        d_a   = 32'd0;
        d_b   = 32'd0;
        d_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_op = {funct7b5, funct3};
                d_a  = rs1_data;
                d_b  = rs2_data;
            end
            OPC_OPIMM: begin
                // Only srai uses bit 30; for other immediates it is immediate data.
                d_op = {(funct3 == 3'd5) ? funct7b5 : 1'b0, funct3};
                d_a  = rs1_data;
                d_b  = imm;
            end
            OPC_LUI: begin
                d_op = OP_COPYA;
                d_a  = imm;
            end
            OPC_AUIPC: begin
                d_a = pc;
                d_b = imm;
            end
            OPC_JAL, OPC_JALR: begin
                // The ALU produces the link value pc+4.
                d_a = pc;
                d_b = 32'd4;
            end
            default: d_ill = 1'b1;
        endcase
    end

    // Issue FSM with operand, result and retire-counter registers; flush wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= 4'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            illegal_q <= 1'b0;
            result    <= 32'd0;
            zero      <= 1'b0;
            retired   <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= EXEC;
                        op_q      <= d_op;
                        a_q       <= d_a;
                        b_q       <= d_b;
                        illegal_q <= d_ill;
                    end
                end
                EXEC: begin
                    result <= alu_out;
                    zero   <= (alu_out == 32'd0);
                    state  <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state   <= IDLE;
                        retired <= retired + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a behavioural ALU closes the alu_op/alu_out loop, and
// expected results are computed per instruction from RISC-V semantics.
module tb_alu_issue;

    localparam int CW = 4;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          funct7b5 = 1'b0;
    logic [31:0]   rs1_data = '0, rs2_data = '0, imm = '0, pc = '0;
    logic          flush = 1'b0;
    logic [3:0]    alu_op;
    logic [31:0]   alu_a, alu_b;
    logic [31:0]   alu_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   result;
    logic          zero;
    logic          illegal;
    logic [CW-1:0] retired;
    logic [1:0]    state_dbg;

    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] exp_retired = '0;

    alu_issue #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .flush(flush), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal), .retired(retired),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Behavioural ALU driven by the DUT's operand registers.
    always_comb begin
        case (alu_op)
            4'd0:    alu_out = alu_a + alu_b;
            4'd8:    alu_out = alu_a - alu_b;
            4'd1:    alu_out = alu_a << alu_b[4:0];
            4'd2:    alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd3:    alu_out = {31'd0, alu_a < alu_b};
            4'd4:    alu_out = alu_a ^ alu_b;
            4'd5:    alu_out = alu_a >> alu_b[4:0];
            4'd13:   alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd6:    alu_out = alu_a | alu_b;
            4'd7:    alu_out = alu_a & alu_b;
            4'd9:    alu_out = alu_a;
            default: alu_out = 32'd0;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [6:0] opc, input logic [2:0] f3,
                                               input logic f7, input logic [31:0] r1, r2, im, p);
        logic [31:0] b;
        logic        is_sub;
        b      = (opc == OP) ? r2 : im;
        is_sub = (opc == OP) && f7;
        if (opc == OP || opc == OPIMM) begin
            case (f3)
                3'd0: return is_sub ? r1 - b : r1 + b;
                3'd1: return r1 << b[4:0];
                3'd2: return ($signed(r1) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: return (r1 < b) ? 32'd1 : 32'd0;
                3'd4: return r1 ^ b;
                3'd5: return f7 ? $unsigned($signed(r1) >>> b[4:0]) : r1 >> b[4:0];
                3'd6: return r1 | b;
                default: return r1 & b;
            endcase
        end
        if (opc == LUI)                return im;
        if (opc == AUIPC)              return p + im;
        if (opc == JAL || opc == JALR) return p + 32'd4;
        return 32'd0;
    endfunction

    function automatic logic is_legal(input logic [6:0] opc);
        return opc == OP || opc == OPIMM || opc == LUI || opc == AUIPC || opc == JAL || opc == JALR;
    endfunction

    function automatic logic [3:0] ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        if (opc == OP)    return {f7, f3};
        if (opc == OPIMM) return {(f3 == 3'd5) && f7, f3};
        if (opc == LUI)   return 4'd9;
        return 4'd0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_fields();
        opcode   = 7'($urandom);
        funct3   = 3'($urandom);
        funct7b5 = 1'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        imm      = $urandom;
        pc       = $urandom;
    endtask

    // Offer one instruction and wait (bounded) for the handshake edge; returns at edge+1.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] r1, r2, im, p, output bit ok);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        ok = (in_ready === 1'b1);
        opcode = opc; funct3 = f3; funct7b5 = f7;
        rs1_data = r1; rs2_data = r2; imm = im; pc = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble_fields();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (zero !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_flags got zero=%b illegal=%b want 0 0", zero, illegal); end
        checks++; if (retired !== '0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
        checks++; if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL reset_operands got op=%0d a=%h b=%h want 0", alu_op, alu_a, alu_b); end
        // Offer an instruction already while reset is released so the first edge accepts it.
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        send(LUI, 3'd0, 1'b0, 32'd0, 32'd0, 32'hABCDE000, 32'd0, ok);
        checks++; if (alu_op !== 4'd9 || in_ready !== 1'b0) begin errors++; $display("FAIL first_accept got op=%0d in_ready=%b want 9 0", alu_op, in_ready); end
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        exp_retired++;
        checks++; if (retired !== exp_retired) begin errors++; $display("FAIL first_retire got %0d want %0d", retired, exp_retired); end
    endtask

    task automatic test_directed();
        logic [6:0]  t_opc[6] = '{OP, OPIMM, OPIMM, LUI, JAL, 7'h7F};
        logic [2:0]  t_f3[6]  = '{3'd0, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0};
        logic        t_f7[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] t_r1[6]  = '{32'd5, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h1234};
        logic [31:0] t_r2[6]  = '{32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'h5678};
        logic [31:0] t_im[6]  = '{32'd0, 32'h404, 32'h404, 32'h12345000, 32'd0, 32'h9};
        logic [31:0] t_pc[6]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h100, 32'h200};
        logic [3:0]  t_op[6]  = '{4'd8, 4'd13, 4'd5, 4'd9, 4'd0, 4'd0};
        logic [31:0] t_res[6] = '{32'hFFFFFFFE, 32'hF8000000, 32'h08000000, 32'h12345000, 32'h104, 32'd0};
        logic        t_ill[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bit ok;
        for (int i = 0; i < 6; i++) begin
            send(t_opc[i], t_f3[i], t_f7[i], t_r1[i], t_r2[i], t_im[i], t_pc[i], ok);
            checks++; if (!ok) begin errors++; $display("FAIL dir%0d_accept timed out waiting for in_ready", i); end
            checks++; if (alu_op !== t_op[i]) begin errors++; $display("FAIL dir%0d_alu_op got %0d want %0d", i, alu_op, t_op[i]); end
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL dir%0d_exec got out_valid=%b in_ready=%b want 0 0", i, out_valid, in_ready); end
            out_ready = 1'b1;
            tick();
            checks++; if (out_valid !== 1'b1 || result !== t_res[i]) begin errors++; $display("FAIL dir%0d_result got v=%b %h want 1 %h", i, out_valid, result, t_res[i]); end
            checks++; if (zero !== (t_res[i] == 32'd0) || illegal !== t_ill[i]) begin errors++; $display("FAIL dir%0d_flags got zero=%b ill=%b want %b %b", i, zero, illegal, t_res[i] == 32'd0, t_ill[i]); end
            tick();
            out_ready = 1'b0;
            exp_retired++;
            checks++; if (retired !== exp_retired || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_retire got ret=%0d v=%b rdy=%b want %0d 0 1", i, retired, out_valid, in_ready, exp_retired); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        send(OP, 3'd4, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0, ok);
        tick();
        for (int i = 0; i < 5; i++) begin
            // Offers arriving while busy must be ignored.
            in_valid = 1'b1;
            scramble_fields();
            tick();
            checks++; if (out_valid !== 1'b1 || result !== 32'hFF00FF00 || in_ready !== 1'b0 || retired !== exp_retired) begin
                errors++; $display("FAIL stall%0d got v=%b res=%h rdy=%b ret=%0d want 1 ff00ff00 0 %0d", i, out_valid, result, in_ready, retired, exp_retired);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_retired++;
        checks++; if (retired !== exp_retired || out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got ret=%0d v=%b want %0d 0", retired, out_valid, exp_retired); end
        tick();
        checks++; if (retired !== exp_retired || out_valid !== 1'b0) begin errors++; $display("FAIL stall_single got ret=%0d v=%b want %0d 0", retired, out_valid, exp_retired); end
    endtask

    task automatic test_flush();
        bit ok;
        // Flush during EXEC.
        send(OP, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, ok);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_exec got rdy=%b v=%b want 1 0", in_ready, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0 || retired !== exp_retired) begin errors++; $display("FAIL flush_exec_after got v=%b ret=%0d want 0 %0d", out_valid, retired, exp_retired); end
        out_ready = 1'b0;
        // Flush during HOLD together with out_ready.
        send(OP, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, ok);
        tick();
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || retired !== exp_retired) begin errors++; $display("FAIL flush_hold got v=%b rdy=%b ret=%0d want 0 1 %0d", out_valid, in_ready, retired, exp_retired); end
        // Flush beats an accept in IDLE.
        opcode = LUI; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got rdy=%b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_after got v=%b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [6:0]  legal[6] = '{OP, OPIMM, LUI, AUIPC, JAL, JALR};
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] r1, r2, im, p, exp_res;
        int          stall;
        bit          ok;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                opc = 7'($urandom);
                while (is_legal(opc)) opc = 7'($urandom);
            end else begin
                opc = legal[$urandom_range(0, 5)];
            end
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            if (opc == OP && f3 != 3'd0 && f3 != 3'd5) f7 = 1'b0;
            r1 = $urandom; r2 = $urandom; im = $urandom; p = $urandom;
            if (n % 5 == 0) r2 = r1;
            if (n % 7 == 0) im = r1 & 32'h1F;
            exp_res = ref_result(opc, f3, f7, r1, r2, im, p);
            stall = $urandom_range(0, 3);
            send(opc, f3, f7, r1, r2, im, p, ok);
            checks++; if (!ok || alu_op !== ref_op(opc, f3, f7)) begin errors++; $display("FAIL rnd%0d_op ok=%0d got %0d want %0d", n, ok, alu_op, ref_op(opc, f3, f7)); end
            tick();
            checks++; if (out_valid !== 1'b1 || result !== exp_res || zero !== (exp_res == 32'd0) || illegal !== !is_legal(opc)) begin
                errors++; $display("FAIL rnd%0d_res opc=%h f3=%0d got v=%b %h z=%b i=%b want 1 %h %b %b", n, opc, f3, out_valid, result, zero, illegal, exp_res, exp_res == 32'd0, !is_legal(opc));
            end
            for (int s = 0; s < stall; s++) begin
                in_valid = 1'($urandom);
                tick();
                checks++; if (out_valid !== 1'b1 || result !== exp_res || retired !== exp_retired) begin errors++; $display("FAIL rnd%0d_hold got v=%b %h ret=%0d want 1 %h %0d", n, out_valid, result, retired, exp_res, exp_retired); end
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rnd%0d_xfer_ready got %b want 0", n, in_ready); end
            tick();
            out_ready = 1'b0;
            exp_retired++;
            checks++; if (retired !== exp_retired || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_retire got ret=%0d v=%b rdy=%b want %0d 0 1", n, retired, out_valid, in_ready, exp_retired); end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        send(JALR, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h40, ok);
        tick();
        checks++; if (out_valid !== 1'b1 || result !== 32'h44) begin errors++; $display("FAIL areset_pre got v=%b %h want 1 00000044", out_valid, result); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || retired !== '0 || result !== 32'd0) begin errors++; $display("FAIL areset_now got v=%b ret=%0d res=%h want 0 0 0", out_valid, retired, result); end
        #2 rst_n = 1'b1;
        exp_retired = '0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_release got rdy=%b want 1", in_ready); end
        tick();
        send(AUIPC, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h20, ok);
        out_ready = 1'b1;
        tick();
        checks++; if (result !== 32'h1020) begin errors++; $display("FAIL areset_next got %h want 00001020", result); end
        tick();
        out_ready = 1'b0;
        exp_retired++;
        checks++; if (retired !== exp_retired) begin errors++; $display("FAIL areset_count got %0d want %0d", retired, exp_retired); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
